// File: rtl/period_meter_pkg.sv
// Shared constants for the period meter: FSM encoding, parameter defaults,
// and the averaging depth used when PERIOD_METER_AVG_EN is defined.
package period_meter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;

    localparam int unsigned W_DEF       = 32;
    localparam logic [31:0] TIMEOUT_DEF = 32'h00FF_FFFF;

    localparam int unsigned AVG_N     = 4;
    localparam int unsigned AVG_SHIFT = $clog2(AVG_N);

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input followed by a history
// flop that yields single-cycle rise/fall pulses in the CCLK domain.
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic CCLK,
    input  logic rstn,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_sr;
    logic                   hist;

    // Synchronizer chain plus one history flop for edge detection.
    always_ff @(posedge CCLK or negedge rstn) begin
        if (!rstn) begin
            sync_sr <= '0;
            hist    <= 1'b0;
        end else begin
            sync_sr <= {sync_sr[SYNC_STAGES-2:0], d};
            hist    <= sync_sr[SYNC_STAGES-1];
        end
    end

    assign q    = sync_sr[SYNC_STAGES-1];
    assign rise = q & ~hist;
    assign fall = ~q & hist;

endmodule

// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave, counted in
// CCLK cycles, with a stall timeout. Optional macro PERIOD_METER_AVG_EN
// reports the truncated mean of every four consecutive measurements.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int unsigned W           = W_DEF,
    parameter logic [W-1:0] TIMEOUT    = W'(TIMEOUT_DEF),
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         CCLK,
    input  logic         rstn,
    input  logic         en,
    input  logic         sig_in,
    output logic [W-1:0] period_out,
    output logic [W-1:0] high_out,
    output logic         valid,
    output logic         timeout,
    output logic         busy
);

    logic         sig_q;
    logic         rise;
    logic         fall;

    logic [1:0]   state,    state_nxt;
    logic [W-1:0] cnt,      cnt_nxt;
    logic [W-1:0] high_tmp, high_tmp_nxt;
    logic [W-1:0] period_nxt, high_nxt;
    logic         valid_nxt, timeout_nxt, busy_nxt;

`ifdef PERIOD_METER_AVG_EN
    logic [W+1:0] psum, psum_nxt, psum_add;
    logic [W+1:0] hsum, hsum_nxt, hsum_add;
    logic [1:0]   idx,  idx_nxt;
`endif

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .CCLK (CCLK),
        .rstn (rstn),
        .d    (sig_in),
        .q    (sig_q),
        .rise (rise),
        .fall (fall)
    );

    // State, counter and output registers.
    always_ff @(posedge CCLK or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            high_tmp   <= '0;
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b0;
`ifdef PERIOD_METER_AVG_EN
            psum       <= '0;
            hsum       <= '0;
            idx        <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            high_tmp   <= high_tmp_nxt;
            period_out <= period_nxt;
            high_out   <= high_nxt;
            valid      <= valid_nxt;
            timeout    <= timeout_nxt;
            busy       <= busy_nxt;
`ifdef PERIOD_METER_AVG_EN
            psum       <= psum_nxt;
            hsum       <= hsum_nxt;
            idx        <= idx_nxt;
`endif
        end
    end

    // Next-state and datapath decode; en=0 overrides everything and holds outputs.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        high_tmp_nxt = high_tmp;
        period_nxt   = period_out;
        high_nxt     = high_out;
        valid_nxt    = 1'b0;
        timeout_nxt  = 1'b0;
`ifdef PERIOD_METER_AVG_EN
        psum_nxt     = psum;
        hsum_nxt     = hsum;
        idx_nxt      = idx;
        psum_add     = psum + (W+2)'(cnt);
        hsum_add     = hsum + (W+2)'(high_tmp);
`endif

        if (!en) begin
            state_nxt = ST_IDLE;
`ifdef PERIOD_METER_AVG_EN
            psum_nxt  = '0;
            hsum_nxt  = '0;
            idx_nxt   = '0;
`endif
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        cnt_nxt      = W'(1);
                        high_tmp_nxt = '0;
                        state_nxt    = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (rise) begin
`ifdef PERIOD_METER_AVG_EN
                        if (idx == 2'(AVG_N - 1)) begin
                            period_nxt = W'(psum_add >> AVG_SHIFT);
                            high_nxt   = W'(hsum_add >> AVG_SHIFT);
                            valid_nxt  = 1'b1;
                            psum_nxt   = '0;
                            hsum_nxt   = '0;
                            idx_nxt    = '0;
                        end else begin
                            psum_nxt   = psum_add;
                            hsum_nxt   = hsum_add;
                            idx_nxt    = idx + 2'd1;
                        end
`else
                        period_nxt = cnt;
                        high_nxt   = high_tmp;
                        valid_nxt  = 1'b1;
`endif
                        cnt_nxt = W'(1);
                    end else if (cnt == TIMEOUT) begin
                        // Stalled input: re-arm so the next measurement starts clean.
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_ARM;
`ifdef PERIOD_METER_AVG_EN
                        psum_nxt    = '0;
                        hsum_nxt    = '0;
                        idx_nxt     = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + W'(1);
                        if (fall) begin
                            high_tmp_nxt = cnt;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        busy_nxt = (state_nxt == ST_ARM) || (state_nxt == ST_MEAS);
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: drives square waves, predicts each
// measurement into a scoreboard queue and checks it when valid pulses.
module tb_period_meter;

    localparam int unsigned W   = 32;
    localparam int unsigned SS  = 2;
    localparam int unsigned TMO = 64;

    logic         CCLK;
    logic         rstn;
    logic         en;
    logic         sig_in;
    logic [W-1:0] period_out;
    logic [W-1:0] high_out;
    logic         valid;
    logic         timeout;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] p;
        logic [W-1:0] h;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   to_cnt  = 0;
    int   last_to_cyc = 0;
    int   last_valid_cyc = 0;
    int   prev_valid_cyc = 0;
    int   rise_cyc = 0;

    period_meter #(
        .W           (W),
        .TIMEOUT     (32'(TMO)),
        .SYNC_STAGES (SS)
    ) dut (
        .CCLK       (CCLK),
        .rstn       (rstn),
        .en         (en),
        .sig_in     (sig_in),
        .period_out (period_out),
        .high_out   (high_out),
        .valid      (valid),
        .timeout    (timeout),
        .busy       (busy)
    );

    initial CCLK = 1'b0;
    always #5 CCLK = ~CCLK;

    always @(posedge CCLK) cyc <= cyc + 1;

    // Scoreboard consumer: every valid pops one prediction.
    always @(negedge CCLK) begin
        exp_t e;
        if (rstn === 1'b1 && valid === 1'b1) begin
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: got period=%0d high=%0d, required no valid", period_out, high_out);
            end else begin
                e = sb.pop_front();
                if (period_out !== e.p || high_out !== e.h) begin
                    errors++;
                    $display("FAIL measurement: got %0d/%0d, required %0d/%0d", period_out, high_out, e.p, e.h);
                end
            end
        end
        if (rstn === 1'b1 && timeout === 1'b1) begin
            to_cnt++;
            last_to_cyc = cyc;
            vectors++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_with_timeout: got valid=%b, required 0", valid);
            end
        end
    end

    task automatic align();
        @(posedge CCLK);
        #1;
    endtask

    task automatic drive_period(input int h, input int l, input bit push);
        exp_t e;
        if (push) begin
            e.p = 32'(h + l);
            e.h = 32'(h);
            sb.push_back(e);
        end
        sig_in   = 1'b1;
        rise_cyc = cyc;
        repeat (h) @(posedge CCLK);
        #1 sig_in = 1'b0;
        repeat (l) @(posedge CCLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge CCLK);
        #1;
    endtask

    task automatic fresh();
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (4) @(posedge CCLK);
        #1 en = 1'b1;
        repeat (3) @(posedge CCLK);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; en = 1'b0; sig_in = 1'b0;
        #2 rstn = 1'b0;
        repeat (3) @(posedge CCLK);
        #1 rstn = 1'b1;
        align();
        en = 1'b1;
        repeat (3) @(posedge CCLK);
        #1;
        for (int i = 0; i < 3; i++) drive_period(5, 5, i < 2);
        sig_in = 1'b1;
        #2 rstn = 1'b0;
        #1;
        vectors++;
        if ({period_out, high_out, valid, timeout, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got p=%0d h=%0d v=%b t=%b b=%b, required all 0",
                     period_out, high_out, valid, timeout, busy);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge CCLK);
            #1 sig_in = ~sig_in;
        end
        vectors++;
        if ({period_out, high_out, busy} !== '0) begin
            errors++;
            $display("FAIL reset_hold: got p=%0d h=%0d b=%b, required all 0", period_out, high_out, busy);
        end
        sig_in = 1'b0;
        #1 rstn = 1'b1;
        align();
        repeat (3) @(posedge CCLK);
        #1;
        for (int i = 0; i < 3; i++) drive_period(5, 5, i < 2);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL reset_recovery: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_symmetric();
        fresh();
        for (int i = 0; i < 5; i++) drive_period(5, 5, i < 4);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL symmetric_count: got %0d pending, required 0", sb.size());
        end
        vectors++;
        if (last_valid_cyc - prev_valid_cyc != 10) begin
            errors++;
            $display("FAIL symmetric_interval: got %0d, required 10", last_valid_cyc - prev_valid_cyc);
        end
    endtask

    task automatic test_asymmetric();
        fresh();
        for (int i = 0; i < 3; i++) drive_period(3, 7, 1'b1);
        for (int i = 0; i < 3; i++) drive_period(12, 4, i < 2);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL asymmetric_count: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_stuck_high();
        int t0;
        fresh();
        t0 = to_cnt;
        sig_in = 1'b1;
        for (int i = 0; i < 200 && to_cnt == t0; i++) @(posedge CCLK);
        #1;
        vectors++;
        if (to_cnt != t0 + 1 || period_out !== 32'd16 || high_out !== 32'd12) begin
            errors++;
            $display("FAIL stuck_high: got to=%0d p=%0d h=%0d, required to=%0d p=16 h=12",
                     to_cnt - t0, period_out, high_out, 1);
        end
        sig_in = 1'b0;
        repeat (4) @(posedge CCLK);
        #1;
    endtask

    task automatic test_enable_drop();
        int t0;
        fresh();
        drive_period(5, 5, 1'b1);
        sig_in = 1'b1;
        repeat (5) @(posedge CCLK);
        #1 sig_in = 1'b0;
        repeat (2) @(posedge CCLK);
        #1 en = 1'b0;
        t0 = to_cnt;
        @(posedge CCLK);
        #1;
        vectors++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_busy: got %b, required 0", busy);
        end
        repeat (3) @(posedge CCLK);
        #1;
        for (int i = 0; i < 3; i++) drive_period(5, 5, 1'b0);
        vectors++;
        if (period_out !== 32'd10 || high_out !== 32'd5 || to_cnt != t0 || sb.size() != 0) begin
            errors++;
            $display("FAIL enable_drop_hold: got p=%0d h=%0d to=%0d pend=%0d, required p=10 h=5 to=0 pend=0",
                     period_out, high_out, to_cnt - t0, sb.size());
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) drive_period(5, 5, i < 2);
        drain();
        vectors++;
        if (sb.size() != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enable_resume: got pend=%0d busy=%b, required pend=0 busy=1", sb.size(), busy);
        end
    endtask

    task automatic test_timeout();
        int t0;
        int rc;
        fresh();
        t0 = to_cnt;
        drive_period(5, 0, 1'b0);
        rc = rise_cyc;
        for (int i = 0; i < 200 && to_cnt == t0; i++) @(posedge CCLK);
        #1;
        vectors++;
        if (to_cnt != t0 + 1 || last_to_cyc != rc + int'(SS) + 1 + int'(TMO)) begin
            errors++;
            $display("FAIL timeout_time: got count=%0d cycle=%0d, required count=1 cycle=%0d",
                     to_cnt - t0, last_to_cyc - rc, int'(SS) + 1 + int'(TMO));
        end
        vectors++;
        if (period_out !== 32'd10 || high_out !== 32'd5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_hold: got p=%0d h=%0d b=%b, required p=10 h=5 b=1", period_out, high_out, busy);
        end
        for (int i = 0; i < 3; i++) drive_period(5, 5, i < 2);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL timeout_resume: got %0d pending, required 0", sb.size());
        end
    endtask

    task automatic test_boundaries();
        int t0;
        fresh();
        for (int i = 0; i < 5; i++) drive_period(1, 1, i < 4);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL min_period: got %0d pending, required 0", sb.size());
        end
        fresh();
        t0 = to_cnt;
        for (int i = 0; i < 3; i++) drive_period(TMO / 2, TMO / 2, i < 2);
        vectors++;
        if (sb.size() != 0 || to_cnt != t0) begin
            errors++;
            $display("FAIL rise_at_timeout: got pend=%0d to=%0d, required pend=0 to=0", sb.size(), to_cnt - t0);
        end
    endtask

`ifdef PERIOD_METER_AVG_EN
    task automatic test_avg();
        exp_t e;
        fresh();
        e.p = 32'd11;
        e.h = 32'd5;
        sb.push_back(e);
        drive_period(5, 5, 1'b0);
        drive_period(5, 5, 1'b0);
        drive_period(6, 6, 1'b0);
        drive_period(6, 6, 1'b0);
        drive_period(5, 5, 1'b0);
        drain();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL avg: got %0d pending, required 0", sb.size());
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef PERIOD_METER_AVG_EN
        test_avg();
`else
        test_symmetric();
        test_asymmetric();
        test_stuck_high();
        test_enable_drop();
        test_timeout();
        test_boundaries();
`endif
        repeat (5) @(posedge CCLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
